// File: rtl/la_pkg.sv
// Shared types and defaults for the logic-analyzer capture controller.
// State encodings are fixed because software decodes out_state directly.
package la_pkg;

  localparam int LA_DEPTH = 4096;
  localparam int LA_AW    = 12;
  localparam int LA_DW    = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4,
    ST_READ  = 3'd5
  } la_state_e;

endpackage

// File: rtl/la_trig_match.sv
// Masked trigger comparator: a probe matches when every care bit
// equals the corresponding bit of the trigger value.
module la_trig_match
  import la_pkg::*;
#(
  parameter int DW = LA_DW
) (
  input  logic [DW-1:0] probe_i,
  input  logic [DW-1:0] mask_i,
  input  logic [DW-1:0] value_i,
  output logic          match_o
);

  assign match_o = ((probe_i ^ value_i) & mask_i) == '0;

endmodule

// File: rtl/la_capture_ctrl.sv
// Capture controller: fills an external ring buffer around a trigger
// and streams the window back oldest-first with 1-cycle read latency.
module la_capture_ctrl
  import la_pkg::*;
#(
  parameter int DEPTH = LA_DEPTH,
  parameter int AW    = LA_AW,
  parameter int DW    = LA_DW
) (
  input  logic          in_clk,
  input  logic          in_rst,
  input  logic          in_arm,
  input  logic          in_abort,
  input  logic          in_sample_en,
  input  logic [DW-1:0] in_probe,
  input  logic [DW-1:0] in_trig_mask,
  input  logic [DW-1:0] in_trig_value,
  input  logic [AW-1:0] in_pretrig,
  input  logic          in_rd_req,
  output logic          out_bram_we,
  output logic [AW-1:0] out_bram_addr,
  output logic [DW-1:0] out_bram_data,
  input  logic [DW-1:0] in_bram_q,
  output logic          out_rd_valid,
  output logic [DW-1:0] out_rd_data,
  output logic          out_rd_last,
  output logic          out_done,
  output logic [2:0]    out_state
);

  localparam logic [AW-1:0] ONE  = AW'(1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  la_state_e     state_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] cnt_q;
  logic [AW-1:0] post_q;
  logic [AW-1:0] trig_q;
  logic [AW-1:0] pre_q;
  logic [AW-1:0] iss_q;
  logic [DW-1:0] mask_q;
  logic [DW-1:0] value_q;
  logic          rd_valid_q;
  logic          rd_last_q;

  logic          match;
  logic          capturing;
  logic          wr_en;
  logic          rd_en;
  logic          is_last;
  logic [AW-1:0] post_ld;

  la_trig_match #(.DW(DW)) u_match (
    .probe_i (in_probe),
    .mask_i  (mask_q),
    .value_i (value_q),
    .match_o (match)
  );

  assign capturing = (state_q == ST_PRE) || (state_q == ST_WAIT) ||
                     (state_q == ST_POST);
  assign wr_en   = capturing && in_sample_en && !in_abort;
  assign rd_en   = ((state_q == ST_DONE) || (state_q == ST_READ)) &&
                   in_rd_req && !in_abort;
  assign is_last = iss_q == LAST;
  assign post_ld = LAST - pre_q;

  assign out_bram_we   = wr_en;
  assign out_bram_addr = wr_en ? wr_ptr_q : (rd_en ? rd_ptr_q : '0);
  assign out_bram_data = in_probe;
  assign out_rd_valid  = rd_valid_q;
  assign out_rd_last   = rd_last_q;
  assign out_rd_data   = rd_valid_q ? in_bram_q : '0;
  assign out_done      = state_q == ST_DONE;
  assign out_state     = state_q;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      post_q     <= '0;
      trig_q     <= '0;
      pre_q      <= '0;
      iss_q      <= '0;
      mask_q     <= '0;
      value_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      rd_last_q  <= rd_en && is_last;
      if (wr_en) wr_ptr_q <= wr_ptr_q + ONE;
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + ONE;
        iss_q    <= iss_q + ONE;
      end
      if (in_abort) begin
        state_q <= ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE: if (in_arm) begin
            mask_q   <= in_trig_mask;
            value_q  <= in_trig_value;
            pre_q    <= in_pretrig;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            iss_q    <= '0;
            state_q  <= (in_pretrig == '0) ? ST_WAIT : ST_PRE;
          end
          ST_PRE: if (in_sample_en) begin
            cnt_q <= cnt_q + ONE;
            if ((cnt_q + ONE) == pre_q) state_q <= ST_WAIT;
          end
          ST_WAIT: if (in_sample_en && match) begin
            trig_q <= wr_ptr_q;
            post_q <= post_ld;
            // rd_ptr doubles as start_addr: oldest sample in the window
            if (post_ld == '0) begin
              rd_ptr_q <= wr_ptr_q - pre_q;
              state_q  <= ST_DONE;
            end else begin
              state_q  <= ST_POST;
            end
          end
          ST_POST: if (in_sample_en) begin
            post_q <= post_q - ONE;
            if (post_q == ONE) begin
              rd_ptr_q <= trig_q - pre_q;
              state_q  <= ST_DONE;
            end
          end
          ST_DONE: if (in_rd_req) begin
            state_q <= is_last ? ST_IDLE : ST_READ;
          end
          ST_READ: if (in_rd_req && is_last) begin
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Directed bench: stimulus pushes expected readout beats into a queue,
// an independent monitor pops and compares each valid beat.
module tb_la_capture_ctrl;
  import la_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic        sen = 1'b0;
  logic        rd_req = 1'b0;
  logic [7:0]  probe = '0;
  logic [7:0]  tmask = '0;
  logic [7:0]  tval = '0;
  logic [11:0] pret = '0;
  logic [7:0]  bram_q = '0;
  logic        bwe;
  logic [11:0] baddr;
  logic [7:0]  bdata;
  logic        rvalid;
  logic [7:0]  rdata;
  logic        rlast;
  logic        done;
  logic [2:0]  st;

  logic [7:0]  mem [4096];
  logic [8:0]  sbq [$];
  logic [8:0]  exp_beat;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  la_capture_ctrl dut (
    .in_clk        (clk),
    .in_rst        (rst),
    .in_arm        (arm),
    .in_abort      (abort),
    .in_sample_en  (sen),
    .in_probe      (probe),
    .in_trig_mask  (tmask),
    .in_trig_value (tval),
    .in_pretrig    (pret),
    .in_rd_req     (rd_req),
    .out_bram_we   (bwe),
    .out_bram_addr (baddr),
    .out_bram_data (bdata),
    .in_bram_q     (bram_q),
    .out_rd_valid  (rvalid),
    .out_rd_data   (rdata),
    .out_rd_last   (rlast),
    .out_done      (done),
    .out_state     (st)
  );

  always @(posedge clk) begin
    if (bwe) mem[baddr] <= bdata;
    bram_q <= mem[baddr];
  end

  always @(negedge clk) begin
    if (rvalid) begin
      n_chk++;
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL rd_beat: unexpected beat data=%h last=%b",
                 rdata, rlast);
      end else begin
        exp_beat = sbq.pop_front();
        if ({rlast, rdata} !== exp_beat) begin
          n_err++;
          $display("FAIL rd_beat: got last=%b data=%h expected last=%b data=%h",
                   rlast, rdata, exp_beat[8], exp_beat[7:0]);
        end
      end
    end else if (rlast) begin
      n_chk++;
      n_err++;
      $display("FAIL rd_last: got last=1 expected 0 without valid");
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] probe_of(input int scn, input int k);
    case (scn)
      0: return (k < 10) ? 8'(k) : ((k == 10) ? 8'hA5 : 8'(k & 127));
      1: return 8'(k) ^ 8'h5A;
      2: return (k == 5000) ? 8'hC3 : 8'(k & 127);
      default: return (k < 3) ? 8'(8'h10 + k) :
                      ((k == 3) ? 8'h35 : 8'(k));
    endcase
  endfunction

  task automatic capture(input int scn, input int pt, input logic [7:0] m,
                         input logic [7:0] v, input int n, input int tk,
                         input bit gaps);
    tmask = m;
    tval  = v;
    pret  = 12'(pt);
    arm   = 1'b1;
    cyc();
    arm   = 1'b0;
    chk("arm_state", int'(st), (pt == 0) ? 2 : 1);
    for (int k = 0; k < n; k++) begin
      if (gaps && k > tk && k < tk + 4) begin
        sen   = 1'b0;
        probe = 8'hEE;
        #1;
        chk("gap_we", int'(bwe), 0);
        cyc();
        chk("gap_state", int'(st), 3);
      end
      sen   = 1'b1;
      probe = probe_of(scn, k);
      #1;
      if (k == tk) begin
        chk("trig_addr", int'(baddr), k % 4096);
        chk("trig_we", int'(bwe), 1);
      end
      cyc();
      if (pt != 0 && k == pt - 1) chk("pre_to_wait", int'(st), 2);
      if (k == tk) chk("trig_state", int'(st), (k == n - 1) ? 4 : 3);
      if (k == n - 2 && k > tk) begin
        chk("post_state", int'(st), 3);
        chk("early_done", int'(done), 0);
      end
    end
    sen = 1'b0;
    cyc();
    cyc();
    chk("done_state", int'(st), 4);
    chk("done_flag", int'(done), 1);
  endtask

  task automatic readout(input int scn, input int sk, input int nb,
                         input bit stride);
    for (int j = 0; j < nb; j++) begin
      sbq.push_back({(j == 4095), probe_of(scn, sk + j)});
      rd_req = 1'b1;
      arm    = (j == 100);
      if (j == 0) begin
        #1;
        chk("rd_start_addr", int'(baddr), sk % 4096);
        chk("rd_we", int'(bwe), 0);
      end
      cyc();
      arm = 1'b0;
      if (j == 0) begin
        chk("read_state", int'(st), (nb == 1) ? 0 : 5);
        chk("done_clear", int'(done), 0);
      end
      if (j == 100) chk("arm_ignored", int'(st), 5);
      if (j == 4095) chk("last_idle", int'(st), 0);
      if (stride) begin
        rd_req = 1'b0;
        cyc();
      end
    end
    if (nb == 4096) begin
      rd_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
        #1;
        chk("idle_rd_we", int'(bwe), 0);
        chk("idle_rd_addr", int'(baddr), 0);
        cyc();
      end
    end
    rd_req = 1'b0;
    repeat (3) cyc();
    chk("sb_drained", sbq.size(), 0);
  endtask

  initial begin
    #2;
    chk("rst_state", int'(st), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(rvalid), 0);
    chk("rst_last", int'(rlast), 0);
    chk("rst_rdata", int'(rdata), 0);
    chk("rst_we", int'(bwe), 0);
    chk("rst_addr", int'(baddr), 0);
    @(negedge clk);
    rst = 1'b0;
    cyc();

    capture(0, 4, 8'hFF, 8'hA5, 4102, 10, 1'b0);
    readout(0, 6, 4096, 1'b0);

    capture(1, 0, 8'h00, 8'h00, 4096, 0, 1'b1);
    readout(1, 0, 4096, 1'b1);

    capture(2, 4095, 8'hFF, 8'hC3, 5001, 5000, 1'b0);
    readout(2, 905, 4096, 1'b0);

    tmask = 8'hFF;
    tval  = 8'h77;
    pret  = 12'd2;
    arm   = 1'b1;
    cyc();
    arm   = 1'b0;
    sen   = 1'b1;
    probe = 8'h01;
    cyc();
    probe = 8'h02;
    cyc();
    chk("abort_pre_wait", int'(st), 2);
    abort = 1'b1;
    probe = 8'h77;
    #1;
    chk("abort_we", int'(bwe), 0);
    cyc();
    abort = 1'b0;
    chk("abort_idle", int'(st), 0);
    chk("abort_done", int'(done), 0);
    #1;
    chk("abort_idle_we", int'(bwe), 0);
    cyc();
    sen = 1'b0;

    capture(3, 1, 8'h0F, 8'h05, 4098, 3, 1'b0);
    readout(3, 2, 10, 1'b0);
    chk("midread_state", int'(st), 5);
    rd_req = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_state", int'(st), 0);
    chk("rst_mid_valid", int'(rvalid), 0);
    chk("rst_mid_done", int'(done), 0);
    chk("rst_mid_rdata", int'(rdata), 0);
    cyc();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) cyc();
    chk("post_rst_state", int'(st), 0);
    chk("post_rst_we", int'(bwe), 0);
    rd_req = 1'b0;

    capture(1, 0, 8'h00, 8'h00, 4096, 0, 1'b0);
    readout(1, 0, 4096, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
